qea_host_loader: RTL and testbench

Sequencer that sits directly upstream of the QEA core and replaces the hand-driven bench sequence.
- Accepts gate-context words on a valid/ready stream and writes them into the QEA context RAM port.
- Initialises the state RAM to |0…0⟩, pulses start, and waits for completion.
- Reads the final state vector back and streams it out on a valid/ready master port.

---
 rtl/qea_host_loader_if.sv | 16 +
 rtl/qea_host_loader.sv | 193 +++++++++++++++++++
 tb/tb_qea_host_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qea_host_loader_if.sv
// rtl/qea_host_loader_if.sv - valid/ready stream bundle for the QEA host loader
// Purpose: carries one word per tvalid&tready handshake.
// Ports (signals):
//   tvalid - word present (driven by master)
//   tready - word accepted (driven by slave)
//   tdata  - word payload, DATA_WIDTH bits (driven by master)
interface qea_host_loader_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/qea_host_loader.sv
// rtl/qea_host_loader.sv - loads QEA context, initialises state RAM, runs the core, streams the result
// Purpose: job sequencer upstream of the QEA core (IDLE->CTX->INIT->START->RUN->readout->DONE).
// Optional feature macro: QEA_LOADER_CYCLE_CNT_EN (start-to-complete cycle counter on o_exec_cycles).
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   i_go, i_qbit_num, i_ins_num   - job request and its parameters (sampled on acceptance)
//   s_ctx (slave stream)          - incoming gate-context words
//   o_ctx_en/wea/addr/data        - QEA context RAM write port
//   o_state_ena/wea/addra/dina    - QEA state RAM port (init writes and readout reads)
//   o_start, i_complete           - core start pulse and completion level
//   i_state_dout                  - state RAM read data, 1-cycle latency
//   m_out (master stream)         - final state vector, one row per handshake
//   o_busy, o_done, o_err         - job status
//   o_exec_cycles                 - RUN cycle count of the last job (0 without the macro)
module qea_host_loader #(
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = DATA_WIDTH * 2,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  qea_host_loader_if.slave                     s_ctx,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  output logic                                 o_start,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  qea_host_loader_if.master                    m_out,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [31:0]                          o_exec_cycles
);
  localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] AMP_ONE  = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // |0..0> amplitude lives in the real field of the topmost lane of row 0
  localparam logic [ROW_W-1:0]      ROW0_INIT = {AMP_ONE, {(ROW_W-DATA_WIDTH){1'b0}}};

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CTX     = 4'd1;
  localparam logic [3:0] ST_INIT    = 4'd2;
  localparam logic [3:0] ST_START   = 4'd3;
  localparam logic [3:0] ST_RUN     = 4'd4;
  localparam logic [3:0] ST_RD_ADDR = 4'd5;
  localparam logic [3:0] ST_RD_WAIT = 4'd6;
  localparam logic [3:0] ST_RD_OUT  = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  logic [3:0]                          r_state;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ctx_cnt;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  r_ins_num;
  logic [STATE_ADDR_WIDTH-1:0]         r_row;
  logic [STATE_ADDR_WIDTH-1:0]         r_last_row;
  logic                                r_first_run;
  logic                                r_err;
  logic [ROW_W-1:0]                    r_m_data;

  logic                                w_qbit_legal;
  logic [STATE_ADDR_WIDTH:0]           w_rows;
  logic [STATE_ADDR_WIDTH-1:0]         w_last_row;
  logic                                w_ctx_ready;
  logic                                w_ctx_hs;
  logic                                w_init;
  logic                                w_rd_addr;

  // Row count 2^(q-2), one extra bit so q = STATE_ADDR_WIDTH+2 still fits before the -1
  always_comb begin
    w_qbit_legal = int'(i_qbit_num) <= STATE_ADDR_WIDTH + 2;
    w_rows       = (STATE_ADDR_WIDTH+1)'(1);
    if (i_qbit_num >= MAX_QBIT_WIDTH'(2))
      w_rows = (STATE_ADDR_WIDTH+1)'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(2));
    w_last_row = STATE_ADDR_WIDTH'(w_rows - 1'b1);
  end

  always_comb begin
    w_ctx_ready = (r_state == ST_CTX) && (r_ctx_cnt < r_ins_num);
    w_ctx_hs    = w_ctx_ready && s_ctx.tvalid;
    w_init      = (r_state == ST_INIT);
    w_rd_addr   = (r_state == ST_RD_ADDR);
  end

  // All RAM-side outputs are decoded from state so an asynchronous reset drops them at once
  assign s_ctx.tready  = w_ctx_ready;
  assign o_ctx_en      = w_ctx_hs;
  assign o_ctx_wea     = w_ctx_hs;
  assign o_ctx_addr    = w_ctx_hs ? r_ctx_cnt : '0;
  assign o_ctx_data    = w_ctx_hs ? s_ctx.tdata : '0;
  assign o_state_ena   = (w_init || w_rd_addr) ? '1 : '0;
  assign o_state_wea   = w_init ? '1 : '0;
  assign o_state_addra = (w_init || w_rd_addr) ? r_row : '0;
  assign o_state_dina  = (w_init && (r_row == '0)) ? ROW0_INIT : '0;
  assign o_start       = (r_state == ST_START);
  assign m_out.tvalid  = (r_state == ST_RD_OUT);
  assign m_out.tdata   = r_m_data;
  assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done        = (r_state == ST_DONE);
  assign o_err         = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ctx_cnt   <= '0;
      r_ins_num   <= '0;
      r_row       <= '0;
      r_last_row  <= '0;
      r_first_run <= 1'b0;
      r_err       <= 1'b0;
      r_m_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_go) begin
            if (w_qbit_legal) begin
              r_err      <= 1'b0;
              r_ins_num  <= i_ins_num;
              r_last_row <= w_last_row;
              r_ctx_cnt  <= '0;
              r_row      <= '0;
              r_state    <= ST_CTX;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_CTX: begin
          if (w_ctx_hs) r_ctx_cnt <= r_ctx_cnt + 1'b1;
          if (r_ctx_cnt == r_ins_num) r_state <= ST_INIT;
        end
        ST_INIT: begin
          if (r_row == r_last_row) begin
            r_row   <= '0;
            r_state <= ST_START;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        ST_START: begin
          r_first_run <= 1'b1;
          r_state     <= ST_RUN;
        end
        ST_RUN: begin
          // The first RUN cycle may still see the previous job's completion level
          r_first_run <= 1'b0;
          if (!r_first_run && i_complete) r_state <= ST_RD_ADDR;
        end
        ST_RD_ADDR: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_m_data <= i_state_dout;
          r_state  <= ST_RD_OUT;
        end
        ST_RD_OUT: begin
          if (m_out.tready) begin
            if (r_row == r_last_row) begin
              r_row   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_row   <= r_row + 1'b1;
              r_state <= ST_RD_ADDR;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef QEA_LOADER_CYCLE_CNT_EN
  logic [31:0] r_exec_cycles;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_exec_cycles <= '0;
    else if (r_state == ST_START) r_exec_cycles <= '0;
    else if (r_state == ST_RUN)   r_exec_cycles <= r_exec_cycles + 1'b1;
  end
  assign o_exec_cycles = r_exec_cycles;
`else
  assign o_exec_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_qea_host_loader.sv
// tb/tb_qea_host_loader.sv - scoreboard testbench for qea_host_loader
module tb_qea_host_loader;
  localparam int PE_NUM = 4;
  localparam int QW     = 6;
  localparam int SDW    = 64;
  localparam int SAW    = 16;
  localparam int CDW    = 64;
  localparam int CAW    = 16;
  localparam int RW     = PE_NUM * SDW;
  localparam logic [RW-1:0] ROW0_EXP = {32'h4000_0000, 224'd0};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_go = 1'b0;
  logic [QW-1:0]       i_qbit_num = '0;
  logic [CAW-1:0]      i_ins_num = '0;
  logic                o_ctx_en, o_ctx_wea;
  logic [CAW-1:0]      o_ctx_addr;
  logic [CDW-1:0]      o_ctx_data;
  logic [PE_NUM-1:0]   o_state_ena, o_state_wea;
  logic [SAW-1:0]      o_state_addra;
  logic [RW-1:0]       o_state_dina;
  logic                o_start;
  logic                i_complete = 1'b0;
  logic [RW-1:0]       i_state_dout = '0;
  logic                o_busy, o_done, o_err;
  logic [31:0]         o_exec_cycles;

  qea_host_loader_if #(.DATA_WIDTH(CDW)) ctx_if();
  qea_host_loader_if #(.DATA_WIDTH(RW))  out_if();

  qea_host_loader dut (
    .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .s_ctx(ctx_if), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr),
    .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
    .o_state_addra(o_state_addra), .o_state_dina(o_state_dina), .o_start(o_start),
    .i_complete(i_complete), .i_state_dout(i_state_dout), .m_out(out_if), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [CAW+CDW-1:0] ctx_q[$];
  logic [SAW+RW-1:0]  init_q[$];
  logic [SAW-1:0]     rd_q[$];
  logic [RW-1:0]      out_q[$];

  // State RAM model with 1-cycle read latency; core_load emulates the core's result
  logic [RW-1:0] mem [0:1023];
  logic          core_load = 1'b0;
  int            core_rows = 0;
  logic [31:0]   core_seed = '0;

  function automatic logic [RW-1:0] pattern(input logic [31:0] seed, input int r);
    logic [RW-1:0] v;
    for (int k = 0; k < RW/32; k++) v[k*32 +: 32] = seed ^ (32'(r) * 32'h9E37_79B1) ^ (32'(k) << 24);
    return v;
  endfunction

  always @(posedge clk) begin
    if (core_load) begin
      for (int r = 0; r < core_rows; r++) mem[r] <= pattern(core_seed, r);
    end else begin
      for (int l = 0; l < PE_NUM; l++)
        if (o_state_ena[l] && o_state_wea[l])
          mem[o_state_addra[9:0]][l*SDW +: SDW] <= o_state_dina[l*SDW +: SDW];
    end
    if (o_state_ena != '0 && o_state_wea == '0) i_state_dout <= mem[o_state_addra[9:0]];
  end

  // Output monitor, sampled on the falling edge
  logic [CAW+CDW-1:0] m_ce;
  logic [SAW+RW-1:0]  m_ie;
  logic [RW-1:0]      prev_data = '0;
  logic               prev_stall = 1'b0;
  int                 start_cnt = 0;
  int                 done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_ctx_en) begin
        if (ctx_q.size() == 0) check_eq("ctx_unexpected_write", RW'(o_ctx_en), '0);
        else begin
          m_ce = ctx_q.pop_front();
          check_eq("ctx_addr", RW'(o_ctx_addr), RW'(m_ce[CAW+CDW-1:CDW]));
          check_eq("ctx_data", RW'(o_ctx_data), RW'(m_ce[CDW-1:0]));
          check_eq("ctx_wea", RW'(o_ctx_wea), RW'(1));
        end
      end
      if (o_state_wea != '0) begin
        if (init_q.size() == 0) check_eq("init_unexpected_write", RW'(o_state_wea), '0);
        else begin
          m_ie = init_q.pop_front();
          check_eq("init_addr", RW'(o_state_addra), RW'(m_ie[SAW+RW-1:RW]));
          check_eq("init_data", o_state_dina, m_ie[RW-1:0]);
          check_eq("init_en", RW'({o_state_ena, o_state_wea}), RW'(8'hFF));
        end
      end
      if (o_state_ena != '0 && o_state_wea == '0) begin
        if (rd_q.size() == 0) check_eq("rd_unexpected", RW'(o_state_ena), '0);
        else check_eq("rd_addr", RW'(o_state_addra), RW'(rd_q.pop_front()));
      end
      if (out_if.tvalid && prev_stall) begin
        check_eq("hold_data", out_if.tdata, prev_data);
        check_eq("hold_no_read", RW'(o_state_ena), '0);
      end
      if (out_if.tvalid && out_if.tready) begin
        if (out_q.size() == 0) check_eq("out_unexpected", RW'(out_if.tvalid), '0);
        else check_eq("out_data", out_if.tdata, out_q.pop_front());
      end
      if (o_start) start_cnt <= start_cnt + 1;
      if (o_done)  done_cnt  <= done_cnt + 1;
      prev_stall <= out_if.tvalid && !out_if.tready;
      prev_data  <= out_if.tdata;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, RW'({o_ctx_en, o_ctx_wea, ctx_if.tready, o_state_ena, o_state_wea,
                                 o_start, out_if.tvalid, o_busy, o_done, o_err}), '0);
    check_eq({tag, "_ctx_bus"}, RW'({o_ctx_addr, o_ctx_data}), '0);
    check_eq({tag, "_state_bus"}, RW'(o_state_addra), '0);
    check_eq({tag, "_dina"}, o_state_dina, '0);
    check_eq({tag, "_m_data"}, out_if.tdata, '0);
    check_eq({tag, "_exec"}, RW'(o_exec_cycles), '0);
  endtask

  // One complete job; called #1 after a rising edge with the DUT idle
  task automatic run_job(input int q, input int ins, input bit toggle_valid, input int stall_row,
                         input bit stale, input int core_lat);
    int rows, idx, guard, s0, d0, t_start, t_rd, exp_run, stall_n;
    bit ph, hs;
    logic [CDW-1:0] words[$];
    logic [31:0] seed;
    logic [RW-1:0] irow;
    rows = (q < 2) ? 1 : (1 << (q - 2));
    seed = $urandom;
    for (int i = 0; i < ins; i++) begin
      words.push_back({$urandom, $urandom});
      ctx_q.push_back({CAW'(i), words[i]});
    end
    for (int r = 0; r < rows; r++) begin
      irow = (r == 0) ? ROW0_EXP : '0;
      init_q.push_back({SAW'(r), irow});
      rd_q.push_back(SAW'(r));
      out_q.push_back(pattern(seed, r));
    end
    exp_run = (stale || core_lat < 2) ? 2 : core_lat;
    s0 = start_cnt; d0 = done_cnt;
    i_complete = stale;
    i_go = 1'b1; i_qbit_num = QW'(q); i_ins_num = CAW'(ins);
    @(posedge clk); #1;
    i_go = 1'b0;
    check_eq("busy_after_go", RW'(o_busy), RW'(1));
    check_eq("err_after_legal_go", RW'(o_err), '0);

    idx = 0; ph = 1'b1; guard = 0;
    while (idx < ins && guard < 2000) begin
      ctx_if.tvalid = toggle_valid ? ph : 1'b1;
      ctx_if.tdata  = ctx_if.tvalid ? words[idx] : {$urandom, $urandom};
      hs = ctx_if.tvalid && ctx_if.tready;
      @(posedge clk); #1;
      if (hs) idx++;
      ph = !ph; guard++;
    end
    ctx_if.tvalid = 1'b0;
    check_eq("ctx_words_sent", RW'(idx), RW'(ins));
    if (!toggle_valid) check_eq("ctx_cycles", RW'(guard), RW'(ins));

    guard = 0;
    while (!o_start && guard < 5000) begin @(posedge clk); #1; guard++; end
    check_eq("start_seen", RW'(o_start), RW'(1));
    check_eq("init_rows_written", RW'(init_q.size()), '0);
    t_start = cyc;
    core_seed = seed; core_rows = rows; core_load = 1'b1;
    @(posedge clk); #1;
    core_load = 1'b0;
    for (int k = 1; k < core_lat; k++) begin @(posedge clk); #1; end
    i_complete = 1'b1;

    guard = 0;
    while (!(o_state_ena != '0 && o_state_wea == '0) && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    t_rd = cyc;
    check_eq("start_to_read", RW'(t_rd - t_start), RW'(exp_run + 1));

    idx = 0; guard = 0; stall_n = 0;
    while (!o_done && guard < 5000) begin
      if (out_if.tvalid && idx == stall_row && stall_n < 5) begin
        out_if.tready = 1'b0; stall_n++;
      end else begin
        out_if.tready = 1'b1;
      end
      hs = out_if.tvalid && out_if.tready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    out_if.tready = 1'b1;
    check_eq("done_pulse", RW'(o_done), RW'(1));
    check_eq("busy_at_done", RW'(o_busy), '0);
    check_eq("rows_delivered", RW'(idx), RW'(rows));
    if (stall_row >= 0 && stall_row < rows) check_eq("stall_cycles", RW'(stall_n), RW'(5));
    @(posedge clk); #1;
    i_complete = 1'b0;
    check_eq("done_single", RW'(o_done), '0);
    check_eq("start_count", RW'(start_cnt - s0), RW'(1));
    check_eq("done_count", RW'(done_cnt - d0), RW'(1));
    check_eq("queues_drained", RW'(ctx_q.size() + rd_q.size() + out_q.size()), '0);
`ifdef QEA_LOADER_CYCLE_CNT_EN
    check_eq("exec_cycles", RW'(o_exec_cycles), RW'(exp_run));
`else
    check_eq("exec_cycles", RW'(o_exec_cycles), '0);
`endif
  endtask

  initial begin
    ctx_if.tvalid = 1'b0;
    ctx_if.tdata  = '0;
    out_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(3, 73, 1'b0, -1, 1'b0, 4);
    run_job(3, 4,  1'b1, -1, 1'b0, 3);
    run_job(4, 5,  1'b0, -1, 1'b1, 1);
    run_job(4, 2,  1'b0, 1,  1'b0, 2);

    i_go = 1'b1; i_qbit_num = QW'(20); i_ins_num = CAW'(3);
    @(posedge clk); #1;
    i_go = 1'b0;
    check_eq("illegal_err", RW'(o_err), RW'(1));
    check_eq("illegal_busy", RW'(o_busy), '0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("illegal_err_sticky", RW'(o_err), RW'(1));
    check_eq("illegal_still_idle", RW'({o_busy, ctx_if.tready}), '0);
    run_job(3, 2, 1'b0, -1, 1'b0, 2);

    for (int i = 0; i < 10; i++) ctx_q.push_back({CAW'(i), 64'hA5A5_0000_0000_0000 | 64'(i)});
    i_go = 1'b1; i_qbit_num = QW'(3); i_ins_num = CAW'(10);
    @(posedge clk); #1;
    i_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ctx_if.tvalid = 1'b1;
      ctx_if.tdata  = 64'hA5A5_0000_0000_0000 | 64'(i);
      @(posedge clk); #1;
    end
    ctx_if.tdata = 64'hA5A5_0000_0000_0003;
    check_eq("pre_reset_ctx_en", RW'(o_ctx_en), RW'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    check_eq("midjob_ctx_consumed", RW'(ctx_q.size()), RW'(7));
    ctx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    ctx_if.tvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(2, 0, 1'b0, -1, 1'b0, 3);
    run_job(1, 1, 1'b0, -1, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
